// File: rtl/lsu_arbiter.sv
// lsu_arbiter: shares one 16-bit load/store unit between an instruction
// fetch port (p0) and a data port (p1). One transaction is in flight at a
// time. Misaligned word accesses can be split into two byte transfers.
//
// Ports:
//   clk, a_rst             clock, asynchronous active-low reset
//   pN_req/addr/data/      requester N: request (held until gnt), byte
//   width/cmd              address, write data, 0=byte/1=word, 0=rd/1=wr
//   pN_gnt, pN_done        one-cycle pulses: request captured / complete
//   rsp_data               read result, valid while the matching done is high
//   rq_addr/data/width/    LSU request; rq_t_id is the winning port,
//   cmd/t_id/start, rq_ack rq_start is held until rq_ack
//   lsu_done, rd_data      LSU completion and read bus
module lsu_arbiter #(
  parameter bit SPLIT_EN = 1'b1,
  parameter bit RR_EN    = 1'b1
) (
  input  logic        clk,
  input  logic        a_rst,
  input  logic        p0_req,
  input  logic [15:0] p0_addr,
  input  logic [15:0] p0_data,
  input  logic        p0_width,
  input  logic        p0_cmd,
  input  logic        p1_req,
  input  logic [15:0] p1_addr,
  input  logic [15:0] p1_data,
  input  logic        p1_width,
  input  logic        p1_cmd,
  output logic        p0_gnt,
  output logic        p1_gnt,
  output logic        p0_done,
  output logic        p1_done,
  output logic [15:0] rsp_data,
  output logic [15:0] rq_addr,
  output logic [15:0] rq_data,
  output logic        rq_width,
  output logic        rq_cmd,
  output logic        rq_t_id,
  output logic        rq_start,
  input  logic        rq_ack,
  input  logic        lsu_done,
  input  logic [15:0] rd_data
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ISSUE_A = 3'd1,
    WAIT_A  = 3'd2,
    ISSUE_B = 3'd3,
    WAIT_B  = 3'd4
  } state_t;

  // Place a byte on the upper (hi=1) or lower byte lane, other lane zero.
  function automatic logic [15:0] lane_place(input logic [7:0] b, input logic hi);
    lane_place = hi ? {b, 8'h00} : {8'h00, b};
  endfunction

  state_t      state_r, state_s;
  logic        rr_ptr_r, rr_ptr_s;
  logic        id_r, id_s;
  logic [15:0] addr_r, addr_s;
  logic [7:0]  data_hi_r, data_hi_s;
  logic        width_r, width_s;
  logic        cmd_r, cmd_s;
  logic        split_r, split_s;
  logic [7:0]  lo_r, lo_s;
  logic        gnt0_s, gnt1_s, done0_s, done1_s;
  logic [15:0] rsp_s, rq_addr_s, rq_data_s;
  logic        rq_width_s, rq_cmd_s, rq_t_id_s, rq_start_s;
  logic        win_s;
  logic [15:0] sel_addr_s, sel_data_s;
  logic        sel_width_s, sel_cmd_s;

  // Next-state, arbitration and next-output logic.
  always_comb begin
    state_s     = state_r;
    rr_ptr_s    = rr_ptr_r;
    id_s        = id_r;
    addr_s      = addr_r;
    data_hi_s   = data_hi_r;
    width_s     = width_r;
    cmd_s       = cmd_r;
    split_s     = split_r;
    lo_s        = lo_r;
    gnt0_s      = 1'b0;
    gnt1_s      = 1'b0;
    done0_s     = 1'b0;
    done1_s     = 1'b0;
    rsp_s       = rsp_data;
    rq_addr_s   = rq_addr;
    rq_data_s   = rq_data;
    rq_width_s  = rq_width;
    rq_cmd_s    = rq_cmd;
    rq_t_id_s   = rq_t_id;
    rq_start_s  = rq_start;
    // On a tie the pointer (or port 0 in fixed mode) wins; a lone request wins outright.
    if (p0_req && p1_req) begin
      win_s = RR_EN ? rr_ptr_r : 1'b0;
    end else begin
      win_s = p1_req;
    end
    sel_addr_s  = win_s ? p1_addr  : p0_addr;
    sel_data_s  = win_s ? p1_data  : p0_data;
    sel_width_s = win_s ? p1_width : p0_width;
    sel_cmd_s   = win_s ? p1_cmd   : p0_cmd;

    case (state_r)
      IDLE: begin
        if (p0_req || p1_req) begin
          gnt0_s     = ~win_s;
          gnt1_s     = win_s;
          rr_ptr_s   = ~win_s;
          id_s       = win_s;
          addr_s     = sel_addr_s;
          data_hi_s  = sel_data_s[15:8];
          width_s    = sel_width_s;
          cmd_s      = sel_cmd_s;
          split_s    = SPLIT_EN & sel_width_s & sel_addr_s[0];
          rq_addr_s  = sel_addr_s;
          rq_cmd_s   = sel_cmd_s;
          rq_t_id_s  = win_s;
          rq_start_s = 1'b1;
          if (SPLIT_EN & sel_width_s & sel_addr_s[0]) begin
            // First half of a split word: low data byte goes out on the odd lane.
            rq_width_s = 1'b0;
            rq_data_s  = lane_place(sel_data_s[7:0], 1'b1);
          end else if (sel_width_s) begin
            rq_width_s = 1'b1;
            rq_data_s  = sel_data_s;
          end else begin
            rq_width_s = 1'b0;
            rq_data_s  = lane_place(sel_data_s[7:0], sel_addr_s[0]);
          end
          state_s = ISSUE_A;
        end else begin
          state_s = IDLE;
        end
      end
      ISSUE_A: begin
        if (rq_ack) begin
          rq_start_s = 1'b0;
          state_s    = WAIT_A;
        end else begin
          rq_start_s = 1'b1;
        end
      end
      WAIT_A: begin
        if (lsu_done && split_r) begin
          // Keep the odd-lane byte; second half targets addr+1 (wraps at 16 bits).
          lo_s       = rd_data[15:8];
          rq_addr_s  = addr_r + 16'd1;
          rq_width_s = 1'b0;
          rq_data_s  = lane_place(data_hi_r, 1'b0);
          rq_start_s = 1'b1;
          state_s    = ISSUE_B;
        end else if (lsu_done) begin
          done0_s = ~id_r;
          done1_s = id_r;
          if (cmd_r) begin
            rsp_s = rsp_data;
          end else if (width_r) begin
            rsp_s = rd_data;
          end else begin
            rsp_s = {8'h00, (addr_r[0] ? rd_data[15:8] : rd_data[7:0])};
          end
          state_s = IDLE;
        end else begin
          state_s = WAIT_A;
        end
      end
      ISSUE_B: begin
        if (rq_ack) begin
          rq_start_s = 1'b0;
          state_s    = WAIT_B;
        end else begin
          rq_start_s = 1'b1;
        end
      end
      WAIT_B: begin
        if (lsu_done) begin
          done0_s = ~id_r;
          done1_s = id_r;
          if (cmd_r) begin
            rsp_s = rsp_data;
          end else begin
            rsp_s = {rd_data[7:0], lo_r};
          end
          state_s = IDLE;
        end else begin
          state_s = WAIT_B;
        end
      end
      default: begin
        rq_start_s = 1'b0;
        state_s    = IDLE;
      end
    endcase
  end

  // State, captured request and registered outputs.
  always_ff @(posedge clk or negedge a_rst) begin
    if (!a_rst) begin
      state_r   <= IDLE;
      rr_ptr_r  <= 1'b0;
      id_r      <= 1'b0;
      addr_r    <= 16'h0000;
      data_hi_r <= 8'h00;
      width_r   <= 1'b0;
      cmd_r     <= 1'b0;
      split_r   <= 1'b0;
      lo_r      <= 8'h00;
      p0_gnt    <= 1'b0;
      p1_gnt    <= 1'b0;
      p0_done   <= 1'b0;
      p1_done   <= 1'b0;
      rsp_data  <= 16'h0000;
      rq_addr   <= 16'h0000;
      rq_data   <= 16'h0000;
      rq_width  <= 1'b0;
      rq_cmd    <= 1'b0;
      rq_t_id   <= 1'b0;
      rq_start  <= 1'b0;
    end else begin
      state_r   <= state_s;
      rr_ptr_r  <= rr_ptr_s;
      id_r      <= id_s;
      addr_r    <= addr_s;
      data_hi_r <= data_hi_s;
      width_r   <= width_s;
      cmd_r     <= cmd_s;
      split_r   <= split_s;
      lo_r      <= lo_s;
      p0_gnt    <= gnt0_s;
      p1_gnt    <= gnt1_s;
      p0_done   <= done0_s;
      p1_done   <= done1_s;
      rsp_data  <= rsp_s;
      rq_addr   <= rq_addr_s;
      rq_data   <= rq_data_s;
      rq_width  <= rq_width_s;
      rq_cmd    <= rq_cmd_s;
      rq_t_id   <= rq_t_id_s;
      rq_start  <= rq_start_s;
    end
  end

endmodule

// File: tb/tb_lsu_arbiter.sv
// Directed testbench for lsu_arbiter: round-robin (default) instance with a
// scripted LSU responder, plus a fixed-priority instance with a trivial one.
module tb_lsu_arbiter;

  logic        clk, a_rst;
  logic        p0_req, p1_req, p0_width, p1_width, p0_cmd, p1_cmd;
  logic [15:0] p0_addr, p1_addr, p0_data, p1_data;
  logic        p0_gnt, p1_gnt, p0_done, p1_done;
  logic [15:0] rsp_data, rq_addr, rq_data, rd_data;
  logic        rq_width, rq_cmd, rq_t_id, rq_start, rq_ack, lsu_done;

  logic        f_p0_req, f_p1_req;
  logic        f_p0_gnt, f_p1_gnt, f_p0_done, f_p1_done;
  logic [15:0] f_rsp_data, f_rq_addr, f_rq_data;
  logic        f_rq_width, f_rq_cmd, f_rq_t_id, f_rq_start, f_rq_ack, f_lsu_done;
  logic [15:0] f_rd_data;

  int checks = 0;
  int failures = 0;

  logic [15:0] rd_q[$];
  logic [15:0] log_addr[$];
  logic [15:0] log_data[$];
  logic        log_width[$];
  logic        log_cmd[$];
  logic        log_id[$];
  int          n_acc = 0;
  int          skip_at = -1;
  int          ack_dly = 0;
  int          resp_idx;
  logic [15:0] hold_exp_addr = 16'h0000;

  lsu_arbiter u_dut (
    .clk(clk), .a_rst(a_rst),
    .p0_req(p0_req), .p0_addr(p0_addr), .p0_data(p0_data), .p0_width(p0_width), .p0_cmd(p0_cmd),
    .p1_req(p1_req), .p1_addr(p1_addr), .p1_data(p1_data), .p1_width(p1_width), .p1_cmd(p1_cmd),
    .p0_gnt(p0_gnt), .p1_gnt(p1_gnt), .p0_done(p0_done), .p1_done(p1_done),
    .rsp_data(rsp_data), .rq_addr(rq_addr), .rq_data(rq_data), .rq_width(rq_width),
    .rq_cmd(rq_cmd), .rq_t_id(rq_t_id), .rq_start(rq_start), .rq_ack(rq_ack),
    .lsu_done(lsu_done), .rd_data(rd_data)
  );

  lsu_arbiter #(.SPLIT_EN(1'b1), .RR_EN(1'b0)) u_fix (
    .clk(clk), .a_rst(a_rst),
    .p0_req(f_p0_req), .p0_addr(16'h0040), .p0_data(16'h0000), .p0_width(1'b0), .p0_cmd(1'b0),
    .p1_req(f_p1_req), .p1_addr(16'h0042), .p1_data(16'h0000), .p1_width(1'b0), .p1_cmd(1'b0),
    .p0_gnt(f_p0_gnt), .p1_gnt(f_p1_gnt), .p0_done(f_p0_done), .p1_done(f_p1_done),
    .rsp_data(f_rsp_data), .rq_addr(f_rq_addr), .rq_data(f_rq_data), .rq_width(f_rq_width),
    .rq_cmd(f_rq_cmd), .rq_t_id(f_rq_t_id), .rq_start(f_rq_start), .rq_ack(f_rq_ack),
    .lsu_done(f_lsu_done), .rd_data(f_rd_data)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Scripted LSU for the main instance: logs each access, acks after ack_dly
  // cycles, then returns lsu_done one idle cycle later with the next rd_q word.
  initial begin
    rq_ack = 1'b0; lsu_done = 1'b0; rd_data = 16'h0000;
    forever begin
      @(negedge clk);
      if (rq_start && a_rst) begin
        resp_idx = n_acc;
        n_acc++;
        log_addr.push_back(rq_addr);
        log_data.push_back(rq_data);
        log_width.push_back(rq_width);
        log_cmd.push_back(rq_cmd);
        log_id.push_back(rq_t_id);
        for (int d = 0; d < ack_dly; d++) begin
          @(negedge clk);
          check_eq("hold_start", {31'd0, rq_start}, 32'd1);
          check_eq("hold_addr", {16'd0, rq_addr}, {16'd0, hold_exp_addr});
        end
        rq_ack = 1'b1;
        @(negedge clk);
        rq_ack = 1'b0;
        @(negedge clk);
        if (resp_idx != skip_at) begin
          if (rd_q.size() > 0) rd_data = rd_q.pop_front();
          else rd_data = 16'h0000;
          lsu_done = 1'b1;
          @(negedge clk);
          lsu_done = 1'b0;
          rd_data = 16'h0000;
        end
      end
    end
  end

  // Minimal LSU for the fixed-priority instance.
  initial begin
    f_rq_ack = 1'b0; f_lsu_done = 1'b0; f_rd_data = 16'h0000;
    forever begin
      @(negedge clk);
      f_lsu_done = f_rq_ack;
      f_rq_ack = f_rq_start & ~f_rq_ack;
    end
  end

  task automatic clear_logs();
    log_addr.delete(); log_data.delete(); log_width.delete();
    log_cmd.delete(); log_id.delete(); rd_q.delete();
  endtask

  // One request on one port; checks grant, done and done latency, then
  // counts any further done pulses in a short window.
  task automatic run_txn(input string tag, input logic port, input logic [15:0] addr,
                         input logic [15:0] data, input logic w, input logic c,
                         output int extra);
    logic got, prev;
    @(negedge clk);
    if (port) begin
      p1_addr = addr; p1_data = data; p1_width = w; p1_cmd = c; p1_req = 1'b1;
    end else begin
      p0_addr = addr; p0_data = data; p0_width = w; p0_cmd = c; p0_req = 1'b1;
    end
    got = 1'b0;
    for (int k = 0; k < 40 && !got; k++) begin
      @(negedge clk); #1;
      got = port ? p1_gnt : p0_gnt;
    end
    check_eq({tag, "_gnt"}, {31'd0, got}, 32'd1);
    p0_req = 1'b0; p1_req = 1'b0;
    got = 1'b0; prev = 1'b0;
    for (int k = 0; k < 100 && !got; k++) begin
      @(negedge clk); #1;
      got = port ? p1_done : p0_done;
      if (!got) prev = lsu_done;
    end
    check_eq({tag, "_done"}, {31'd0, got}, 32'd1);
    check_eq({tag, "_done_lat"}, {31'd0, prev}, 32'd1);
    extra = 0;
    repeat (4) begin
      @(negedge clk); #1;
      extra += int'(p0_done | p1_done);
    end
  endtask

  initial begin
    int extra;
    logic got;
    a_rst = 1'b0;
    p0_req = 1'b0; p1_req = 1'b0; p0_addr = 16'h0; p1_addr = 16'h0;
    p0_data = 16'h0; p1_data = 16'h0; p0_width = 1'b0; p1_width = 1'b0;
    p0_cmd = 1'b0; p1_cmd = 1'b0; f_p0_req = 1'b0; f_p1_req = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check_eq("rst_ctrl", {24'd0, p0_gnt, p1_gnt, p0_done, p1_done, rq_start, rq_width, rq_cmd, rq_t_id}, 32'd0);
    check_eq("rst_rq", {rq_addr, rq_data}, 32'd0);
    check_eq("rst_rsp", {16'd0, rsp_data}, 32'd0);
    a_rst = 1'b1;

    // Round robin with both ports held: p0, p1, p0, p1.
    @(negedge clk);
    p0_addr = 16'h0100; p0_width = 1'b1; p0_cmd = 1'b0;
    p1_addr = 16'h0200; p1_width = 1'b1; p1_cmd = 1'b0;
    p0_req = 1'b1; p1_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      got = 1'b0;
      for (int k = 0; k < 60 && !got; k++) begin
        @(negedge clk); #1;
        got = p0_gnt | p1_gnt;
      end
      check_eq($sformatf("rr_gnt%0d", i), {30'd0, p1_gnt, p0_gnt}, (i % 2 == 1) ? 32'd2 : 32'd1);
    end
    p0_req = 1'b0; p1_req = 1'b0;
    repeat (20) @(negedge clk);

    // Fixed priority with both held: p0 three times, then p1 once p0 lets go.
    f_p0_req = 1'b1; f_p1_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) f_p0_req = 1'b0;
      got = 1'b0;
      for (int k = 0; k < 60 && !got; k++) begin
        @(negedge clk); #1;
        got = f_p0_gnt | f_p1_gnt;
      end
      check_eq($sformatf("fix_gnt%0d", i), {30'd0, f_p1_gnt, f_p0_gnt}, (i == 3) ? 32'd2 : 32'd1);
    end
    f_p0_req = 1'b0; f_p1_req = 1'b0;
    repeat (10) @(negedge clk);

    // p0 word read at 0x1000.
    clear_logs();
    rd_q.push_back(16'hBEEF);
    run_txn("rdw", 1'b0, 16'h1000, 16'h0000, 1'b1, 1'b0, extra);
    check_eq("rdw_rsp", {16'd0, rsp_data}, 32'h0000BEEF);
    check_eq("rdw_nacc", log_addr.size(), 32'd1);
    check_eq("rdw_addr", {16'd0, log_addr[0]}, 32'h00001000);
    check_eq("rdw_wid_id", {30'd0, log_width[0], log_id[0]}, 32'd2);

    // p1 misaligned word write 0xA55A at 0x2001: two byte accesses.
    clear_logs();
    run_txn("wrs", 1'b1, 16'h2001, 16'hA55A, 1'b1, 1'b1, extra);
    check_eq("wrs_nacc", log_addr.size(), 32'd2);
    check_eq("wrs_a", {log_addr[0], log_data[0]}, 32'h20015A00);
    check_eq("wrs_b", {log_addr[1], log_data[1]}, 32'h200200A5);
    check_eq("wrs_wid_cmd", {28'd0, log_width[0], log_width[1], log_cmd[0], log_cmd[1]}, 32'h3);
    check_eq("wrs_id", {31'd0, log_id[1]}, 32'd1);
    check_eq("wrs_single_done", extra, 32'd0);
    check_eq("wrs_rsp_hold", {16'd0, rsp_data}, 32'h0000BEEF);

    // Split read at 0xFFFF wraps to 0x0000.
    clear_logs();
    rd_q.push_back(16'h3400);
    rd_q.push_back(16'h0012);
    run_txn("rds", 1'b0, 16'hFFFF, 16'h0000, 1'b1, 1'b0, extra);
    check_eq("rds_addrs", {log_addr[0], log_addr[1]}, 32'hFFFF0000);
    check_eq("rds_rsp", {16'd0, rsp_data}, 32'h00001234);

    // Odd byte read with rq_ack held off for 3 cycles.
    clear_logs();
    rd_q.push_back(16'hC700);
    ack_dly = 3;
    hold_exp_addr = 16'h0031;
    run_txn("rdb", 1'b1, 16'h0031, 16'h0000, 1'b0, 1'b0, extra);
    ack_dly = 0;
    check_eq("rdb_rsp", {16'd0, rsp_data}, 32'h000000C7);
    check_eq("rdb_wid", {31'd0, log_width[0]}, 32'd0);

    // Reset while waiting for the second half of a split read.
    clear_logs();
    rd_q.push_back(16'h1100);
    skip_at = n_acc + 1;
    @(negedge clk);
    p0_addr = 16'h0101; p0_width = 1'b1; p0_cmd = 1'b0; p0_req = 1'b1;
    got = 1'b0;
    for (int k = 0; k < 40 && !got; k++) begin
      @(negedge clk); #1;
      got = p0_gnt;
    end
    check_eq("mrst_gnt", {31'd0, got}, 32'd1);
    p0_req = 1'b0;
    got = 1'b0;
    for (int k = 0; k < 60 && !got; k++) begin
      @(negedge clk); #1;
      got = (n_acc > skip_at) && rq_ack;
    end
    check_eq("mrst_reach_b", {31'd0, got}, 32'd1);
    @(negedge clk);
    a_rst = 1'b0;
    #1;
    check_eq("mrst_ctrl", {24'd0, p0_gnt, p1_gnt, p0_done, p1_done, rq_start, rq_width, rq_cmd, rq_t_id}, 32'd0);
    check_eq("mrst_rq", {rq_addr, rq_data}, 32'd0);
    check_eq("mrst_rsp", {16'd0, rsp_data}, 32'd0);
    repeat (2) @(negedge clk);
    a_rst = 1'b1;
    skip_at = -1;
    extra = 0;
    repeat (5) begin
      @(negedge clk); #1;
      extra += int'(p0_done | p1_done);
    end
    check_eq("mrst_no_done", extra, 32'd0);
    p0_addr = 16'h0300; p0_width = 1'b1;
    p1_addr = 16'h0400; p1_width = 1'b1; p1_cmd = 1'b0;
    p0_req = 1'b1; p1_req = 1'b1;
    got = 1'b0;
    for (int k = 0; k < 40 && !got; k++) begin
      @(negedge clk); #1;
      got = p0_gnt | p1_gnt;
    end
    check_eq("mrst_regnt", {30'd0, p1_gnt, p0_gnt}, 32'd1);
    p0_req = 1'b0; p1_req = 1'b0;
    repeat (20) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
